// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - single-cycle ALU with iterative multiply/divide and HI/LO registers
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] sh;
    assign sh = a[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            4'd1:    result = a + b;
            4'd2:    result = a - b;
            4'd3:    result = a & b;
            4'd4:    result = a | b;
            4'd5:    result = a ^ b;
            4'd6:    result = ~(a | b);
            4'd7:    result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd8:    result = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd9:    result = b << sh;
            4'd10:   result = b >> sh;
            4'd11:   result = $unsigned($signed(b) >>> sh);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_save;
    logic [SHW-1:0]     cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div0;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;
    logic               last;
    logic               launch;
    logic               sgn_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};
        step_next = is_div ? div_next : mul_next;
        prod_fix  = neg_q ? -step_next : step_next;
        if (!is_div) begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end else if (div0) begin
            fin_hi = a_save;
            fin_lo = '1;
        end else begin
            fin_hi = neg_r ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
            fin_lo = neg_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
        end
    end

    // A new launch is also taken on the edge that retires the current op
    assign last   = busy && (cnt == SHW'(WIDTH-1));
    assign launch = start && (op[3:2] == 2'b11) && (!busy || last);
    assign sgn_op = ~op[0];
    assign a_mag  = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign b_mag  = (sgn_op && b[WIDTH-1]) ? -b : b;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_save <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                acc <= step_next;
                cnt <= cnt + 1'b1;
                if (last) begin
                    hi   <= fin_hi;
                    lo   <= fin_lo;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
            if (launch) begin
                busy   <= 1'b1;
                cnt    <= '0;
                is_div <= op[1];
                a_save <= a;
                neg_q  <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= sgn_op && a[WIDTH-1];
                div0   <= op[1] && (b == '0);
                if (op[1]) begin
                    acc  <= {{WIDTH{1'b0}}, a_mag};
                    opnd <= b_mag;
                end else begin
                    acc  <= {{WIDTH{1'b0}}, b_mag};
                    opnd <= a_mag;
                end
            end
        end
    end
endmodule
